// File: rtl/video_pkg.sv
// Shared video-stream types: frame geometry defaults, RGB444 pixel, framed beat and
// the camera front-end state encoding.
package video_pkg;

    localparam int DEF_IMG_W = 320;
    localparam int DEF_IMG_H = 240;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic    sop;
        logic    eop;
        rgb444_t rgb;
    } pixel_beat_t;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        ACTIVE,
        DROP
    } cam_state_e;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous show-ahead FIFO: head_dat is valid whenever !empty, pushed data is visible
// the cycle after the write; a push while full is taken only if a pop happens that cycle.
module stream_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/camera_stream_source.sv
// Byte-serial RGB444 camera to framed 12-bit ready/valid stream; pixel visible the cycle
// after its second byte. Back-pressure is absorbed by the FIFO; a frame overflowing it is dropped.
module camera_stream_source
    import video_pkg::*;
#(
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic        cam_byte_valid,
    input  logic [7:0]  cam_data,
    input  logic        ready_in,
    output logic        valid_out,
    output logic [11:0] data_out,
    output logic        startofpacket_out,
    output logic        endofpacket_out,
    output logic        frame_error,
    output logic        overflow_sticky
);

    localparam logic [8:0] COL_LAST = 9'(IMG_W - 1);
    localparam logic [7:0] ROW_LAST = 8'(IMG_H - 1);

    cam_state_e  state, state_nxt;
    logic        vsync_q, href_q;
    logic        vsync_rise, vsync_fall, href_rise, href_fall;
    logic        phase;
    logic [3:0]  r_hold;
    logic [8:0]  col;
    logic [7:0]  row;
    logic        accept, byte0, pix_done, in_range, pix_sop, pix_eop;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic        ovf, abort;
    pixel_beat_t beat_in, beat_head;

    assign vsync_rise = cam_vsync && !vsync_q;
    assign vsync_fall = !cam_vsync && vsync_q;
    assign href_rise  = cam_href && !href_q;
    assign href_fall  = !cam_href && href_q;

    // A byte landing on the href rising edge always starts a new pixel.
    assign accept   = cam_byte_valid && cam_href && (state == ACTIVE);
    assign byte0    = accept && (href_rise || !phase);
    assign pix_done = accept && phase && !href_rise;
    assign in_range = (col <= COL_LAST) && (row <= ROW_LAST);
    assign pix_sop  = (col == '0) && (row == '0);
    assign pix_eop  = (col == COL_LAST) && (row == ROW_LAST);

    assign beat_in.sop   = pix_sop;
    assign beat_in.eop   = pix_eop;
    assign beat_in.rgb.r = r_hold;
    assign beat_in.rgb.g = cam_data[7:4];
    assign beat_in.rgb.b = cam_data[3:0];

    assign fifo_pop = !fifo_empty && ready_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= WAIT_SYNC;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_SYNC: if (vsync_fall) state_nxt = ACTIVE;
            ACTIVE: begin
                if (ovf)                                         state_nxt = DROP;
                else if ((fifo_push && pix_eop) || vsync_rise)   state_nxt = WAIT_SYNC;
            end
            DROP:      if (vsync_rise) state_nxt = WAIT_SYNC;
            default:   state_nxt = WAIT_SYNC;
        endcase
    end

    always_comb begin
        fifo_push = 1'b0;
        ovf       = 1'b0;
        abort     = 1'b0;
        if (state == ACTIVE) begin
            if (pix_done && in_range) begin
                if (!fifo_full || fifo_pop) fifo_push = 1'b1;
                else                        ovf       = 1'b1;
            end
            abort = ovf || (vsync_rise && !(fifo_push && pix_eop));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q         <= 1'b0;
            href_q          <= 1'b0;
            phase           <= 1'b0;
            r_hold          <= '0;
            col             <= '0;
            row             <= '0;
            frame_error     <= 1'b0;
            overflow_sticky <= 1'b0;
        end else begin
            vsync_q     <= cam_vsync;
            href_q      <= cam_href;
            frame_error <= abort;
            if (ovf) overflow_sticky <= 1'b1;
            if (byte0) r_hold <= cam_data[3:0];

            if (state == WAIT_SYNC && vsync_fall) begin
                col   <= '0;
                row   <= '0;
                phase <= 1'b0;
            end else begin
                if (href_rise)   phase <= accept;
                else if (accept) phase <= !phase;
                // Saturating counters keep over-long lines/frames out of range.
                if (href_fall) begin
                    col <= '0;
                    if (col != '0 && row != 8'hFF) row <= row + 1'b1;
                end else if (pix_done && col != 9'h1FF) begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    stream_fifo #(
        .WIDTH ($bits(pixel_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .push_dat (beat_in),
        .pop      (fifo_pop),
        .head_dat (beat_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign valid_out         = !fifo_empty;
    assign data_out          = valid_out ? beat_head.rgb : '0;
    assign startofpacket_out = valid_out && beat_head.sop;
    assign endofpacket_out   = valid_out && beat_head.eop;

endmodule

// File: tb/tb_camera_stream_source.sv
// Bench for camera_stream_source: random camera traffic on a reduced frame, checked each
// cycle against a frame-level scoreboard of expected beats, errors and sticky flag.
module tb_camera_stream_source;

    localparam int W = 32;
    localparam int H = 8;
    localparam int D = 16;
    localparam int M_WAIT = 0;
    localparam int M_ACT  = 1;
    localparam int M_DROP = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cam_vsync = 1'b0, cam_href = 1'b0, cam_byte_valid = 1'b0;
    logic [7:0]  cam_data = '0;
    logic        ready_in = 1'b0;
    logic        valid_out, startofpacket_out, endofpacket_out, frame_error, overflow_sticky;
    logic [11:0] data_out;

    always #5 clk = ~clk;

    camera_stream_source #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cam_vsync         (cam_vsync),
        .cam_href          (cam_href),
        .cam_byte_valid    (cam_byte_valid),
        .cam_data          (cam_data),
        .ready_in          (ready_in),
        .valid_out         (valid_out),
        .data_out          (data_out),
        .startofpacket_out (startofpacket_out),
        .endofpacket_out   (endofpacket_out),
        .frame_error       (frame_error),
        .overflow_sticky   (overflow_sticky)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: beats the FIFO should hold, frame mode, pending error pulse, sticky flag.
    logic [13:0] exp_q[$];
    int          mode = M_WAIT;
    logic        exp_err = 1'b0, exp_sticky = 1'b0, prev_vs = 1'b0;
    int          rdy_mode = 0;
    bit          gaps = 0, pattern = 0;
    int          beats, sops, eops, seen_err, exp_err_cnt = 0, total_err = 0;

    task automatic clear_stats();
        beats = 0; sops = 0; eops = 0; seen_err = 0;
    endtask

    task automatic tick(input logic vs, input logic hr, input logic bv, input logic [7:0] d,
                        input logic pv, input int pc, input int pr, input logic [11:0] prgb);
        logic        pop, can_push, ev;
        logic [13:0] h, ent;
        logic [16:0] got, exp;
        cam_vsync = vs; cam_href = hr; cam_byte_valid = bv; cam_data = d;
        ready_in = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        @(negedge clk);
        ev  = (exp_q.size() > 0);
        h   = ev ? exp_q[0] : 14'h0;
        got = {valid_out, frame_error, overflow_sticky,
               ev ? {startofpacket_out, endofpacket_out, data_out} : 14'h0};
        exp = {ev, exp_err, exp_sticky, h};
        check_val("beat", 32'(got), 32'(exp));
        if (valid_out && ready_in) begin
            beats++; sops += int'(startofpacket_out); eops += int'(endofpacket_out);
        end
        if (frame_error) begin seen_err++; total_err++; end
        // Effect of the coming clock edge
        pop      = ev && ready_in;
        can_push = (exp_q.size() < D) || pop;
        exp_err  = 1'b0;
        if (pop) void'(exp_q.pop_front());
        if (pv && mode == M_ACT && pc < W && pr < H) begin
            ent = {(pc == 0 && pr == 0), (pc == W-1 && pr == H-1), prgb};
            if (can_push) begin
                exp_q.push_back(ent);
                if (ent[12]) mode = M_WAIT;
            end else begin
                exp_err = 1'b1; exp_sticky = 1'b1; mode = M_DROP;
            end
        end
        if (vs && !prev_vs) begin
            if (mode == M_ACT) begin exp_err = 1'b1; mode = M_WAIT; end
            else if (mode == M_DROP) mode = M_WAIT;
        end
        if (!vs && prev_vs && mode == M_WAIT) mode = M_ACT;
        prev_vs = vs;
        if (exp_err) exp_err_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic vs, input logic hr);
        tick(vs, hr, 1'b0, 8'($urandom), 1'b0, 0, 0, 12'h0);
    endtask

    task automatic send_pixel(input int c, input int r, input logic [7:0] b0, input logic [7:0] b1);
        if (gaps) repeat ($urandom_range(0, 1)) idle(1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, b0, 1'b0, 0, 0, 12'h0);
        if (gaps) repeat ($urandom_range(0, 1)) idle(1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, b1, 1'b1, c, r, {b0[3:0], b1});
    endtask

    task automatic frame_begin();
        repeat (3) idle(1'b1, 1'b0);
        repeat (3) idle(1'b0, 1'b0);
    endtask

    task automatic send_frame(input int nl, input int np, input int stall_row, input bit abc);
        logic [7:0] b0, b1;
        int saved;
        clear_stats();
        frame_begin();
        for (int r = 0; r < nl; r++) begin
            saved = rdy_mode;
            if (r == stall_row) rdy_mode = 2;
            for (int c = 0; c < np; c++) begin
                if (abc && r == 0 && c == 0) begin
                    send_pixel(0, 0, 8'h0A, 8'hBC);
                    check_val("abc_valid", 32'(valid_out), 32'd1);
                    check_val("abc_data", 32'(data_out), 32'hABC);
                    check_val("abc_sop", 32'(startofpacket_out), 32'd1);
                end else begin
                    b0 = pattern ? {4'($urandom), 4'(c)} : 8'($urandom);
                    b1 = pattern ? {4'(r), 4'(c >> 4)} : 8'($urandom);
                    send_pixel(c, r, b0, b1);
                end
            end
            rdy_mode = saved;
            repeat (3) idle(1'b0, 1'b0);
        end
        idle(1'b1, 1'b0);
        for (int n = 0; n < 300 && exp_q.size() > 0; n++) idle(1'b1, 1'b0);
        repeat (3) idle(1'b1, 1'b0);
    endtask

    initial begin
        clear_stats();
        repeat (3) idle(1'b0, 1'b0);
        check_val("reset_state", 32'({valid_out, data_out, startofpacket_out, endofpacket_out,
                                      frame_error, overflow_sticky}), 32'd0);
        reset_n = 1'b1;
        repeat (2) idle(1'b0, 1'b0);

        // Ordered pattern frame, never stalled
        pattern = 1; rdy_mode = 0;
        send_frame(H, W, -1, 0);
        check_val("f1_beats", 32'(beats), 32'(W*H));
        check_val("f1_sop", 32'(sops), 32'd1);
        check_val("f1_eop", 32'(eops), 32'd1);
        check_val("f1_err", 32'(seen_err), 32'd0);

        // Random data with byte gaps; first pixel is 0x0A,0xBC
        pattern = 0; gaps = 1;
        send_frame(H, W, -1, 1);
        check_val("f2_beats", 32'(beats), 32'(W*H));

        // Whole line stalled: FIFO fills, frame dropped, held beats drain
        send_frame(H, W, 1, 0);
        check_val("ovf_beats", 32'(beats), 32'(W + D));
        check_val("ovf_err", 32'(seen_err), 32'd1);
        check_val("ovf_sticky", 32'(overflow_sticky), 32'd1);
        check_val("ovf_eop", 32'(eops), 32'd0);
        rdy_mode = 1;
        send_frame(H, W, -1, 0);
        check_val("post_ovf_sop", 32'(sops), 32'd1);
        check_val("post_ovf_beats", 32'(beats), 32'(W*H));

        // Oversized lines and frame
        send_frame(H + 5, W + 10, -1, 0);
        check_val("big_beats", 32'(beats), 32'(W*H));
        check_val("big_eop", 32'(eops), 32'd1);
        check_val("big_err", 32'(seen_err), 32'd0);

        // vsync rises early
        send_frame(H - 3, W, -1, 0);
        check_val("abort_err", 32'(seen_err), 32'd1);
        check_val("abort_eop", 32'(eops), 32'd0);
        send_frame(H, W, -1, 0);
        check_val("post_abort_sop", 32'(sops), 32'd1);
        check_val("post_abort_eop", 32'(eops), 32'd1);

        // Reset mid-line with beats waiting
        clear_stats();
        rdy_mode = 2;
        frame_begin();
        for (int c = 0; c < 6; c++) send_pixel(c, 0, 8'($urandom), 8'($urandom));
        check_val("rst_pre_valid", 32'(valid_out), 32'd1);
        #3 reset_n = 1'b0;
        #1 check_val("rst_outputs", 32'({valid_out, data_out, startofpacket_out, endofpacket_out,
                                         frame_error, overflow_sticky}), 32'd0);
        exp_q.delete(); mode = M_WAIT; exp_err = 1'b0; exp_sticky = 1'b0; prev_vs = 1'b0;
        @(posedge clk); #1;
        repeat (2) idle(1'b0, 1'b1);
        reset_n = 1'b1;
        rdy_mode = 0;
        for (int c = 6; c < W; c++) send_pixel(c, 0, 8'($urandom), 8'($urandom));
        repeat (3) idle(1'b0, 1'b0);
        check_val("rst_no_beats", 32'(beats), 32'd0);
        rdy_mode = 1;
        send_frame(H, W, -1, 0);
        check_val("post_rst_beats", 32'(beats), 32'(W*H));
        check_val("post_rst_sop", 32'(sops), 32'd1);

        check_val("err_pulses", 32'(total_err), 32'(exp_err_cnt));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/camera_stream_source.md
# camera_stream_source

Converts the camera's byte-serial RGB444 output into the 12-bit ready/valid pixel stream, with start/end-of-packet framing, that the video filter chain consumes. Sits directly upstream of the brightness/blur/edge filter. Pairs bytes into pixels, tracks column/row position, and tags the first and last pixel of each 320x240 frame. Absorbs downstream back-pressure in a small FIFO; frames that overflow it are discarded cleanly.

## Interface
- IMG_W, 320: active pixels per line
- IMG_H, 240: active lines per frame
- FIFO_DEPTH, 16: pixel beats buffered; power of two, ≥ 4
- clk  in  1  system clock; camera signals are already synchronous to it
- reset_n  in  1  reset, asynchronous assert, active-low
- cam_vsync  in  1  high = vertical blanking / frame boundary
- cam_href  in  1  high = active line
- cam_byte_valid  in  1  strobe; cam_data is valid this cycle
- cam_data  in  8  camera byte
- ready_in  in  1  downstream can accept a beat
- valid_out  out  1  beat available
- data_out  out  12  {R[3:0], G[3:0], B[3:0]}
- startofpacket_out  out  1  beat is pixel (0,0)
- endofpacket_out  out  1  beat is pixel (IMG_W-1, IMG_H-1)
- frame_error  out  1  one-cycle pulse: current frame aborted
- overflow_sticky  out  1  set on any dropped pixel; cleared only by reset

## Operation
- Byte pairing: a byte is accepted only when cam_byte_valid && cam_href && state==ACTIVE. The phase bit toggles per accepted byte and clears on the rising edge of cam_href. Byte 0 gives R = byte0[3:0]; byte 1 gives {G,B} = byte1. A pixel completes on byte 1.
- Position: col (9 b) increments per completed pixel. On the falling edge of cam_href, col clears and row (8 b) increments if col ≠ 0. Pixels with col ≥ IMG_W or row ≥ IMG_H are discarded silently.
- Tagging: sop = (col==0 && row==0); eop = (col==IMG_W-1 && row==IMG_H-1).
- FIFO entry is {sop, eop, rgb}, 14 b.
- States:
  - WAIT_SYNC (reset state): on a cam_vsync falling edge, clear col/row/phase and go to ACTIVE.
  - ACTIVE: a completed pixel is pushed if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
    - Pixel completes while the FIFO is full with no pop: discard it, pulse frame_error, set overflow_sticky, go to DROP.
    - cam_vsync rises before eop has been pushed: pulse frame_error, go to WAIT_SYNC.
    - eop pushed: go to WAIT_SYNC.
  - DROP: accept nothing; go to WAIT_SYNC when cam_vsync rises.
- Beats already in the FIFO from an aborted frame still drain. Downstream resynchronises on the next sop.
- Output: valid_out = FIFO not empty. data_out/sop/eop show the FIFO head (show-ahead). Pop when valid_out && ready_in.
- Edges of cam_vsync and cam_href are detected against one registered copy of each.

## Timing
- Reset values: valid_out 0, data_out 0, startofpacket_out 0, endofpacket_out 0, frame_error 0, overflow_sticky 0. FIFO empty, state WAIT_SYNC, col/row/phase 0.
- Reset asserted mid-frame clears everything immediately. After release, output resumes only after the next vsync falling edge.
- Latency: byte 1 is sampled at edge k; the pixel is written at edge k; valid_out is high in cycle k+1 if the FIFO was empty.
- Throughput: one pixel per 2 accepted bytes. Sustained output is 1 beat/cycle when ready_in is high.
- Push and pop in the same cycle keep the occupancy unchanged, including when full.
- frame_error is high for exactly one cycle per aborted frame, never for a frame that completes.
- data_out/sop/eop are held stable while valid_out && !ready_in.

## Structure
- Shared package video_pkg:
  - IMG_W and IMG_H defaults.
  - rgb444_t as a packed struct {r, g, b}, 4 b each.
  - pixel_beat_t as a packed struct {sop, eop, rgb444_t}.
  - State enum cam_state_e {WAIT_SYNC, ACTIVE, DROP}.
- Sub-module stream_fifo: parameterised width/depth, synchronous show-ahead FIFO with push/pop/full/empty and asynchronous active-low reset. It is reusable for other stages.

## Test plan
- Full frame, ready_in always 1, pixel (c,r) = {c[3:0], r[3:0], c[7:4]}:
  - exactly 76800 beats; sop only on beat 0, eop only on beat 76799; data matches; frame_error never pulses.
- Bytes 0x0A, 0xBC on line 0 after vsync falls:
  - data_out = 0xABC, startofpacket_out = 1, valid_out high one cycle after the 0xBC byte is accepted.
- ready_in held 0 for a whole line with FIFO_DEPTH=16:
  - 16 beats are held; frame_error pulses once and overflow_sticky = 1.
  - The 16 beats drain when ready_in returns.
  - No further beats appear until the next frame, whose sop is correct.
- Extra inputs: lines of 330 pixels and 245 lines:
  - only 320x240 beats are emitted, eop at (319,239), no error.
- cam_vsync rises after row 100:
  - frame_error pulses once, no eop is emitted, and the next frame starts with a clean sop.
- reset_n dropped mid-line with valid_out=1:
  - all outputs are 0 asynchronously, the FIFO is empty, and output resumes only after the following vsync fall.
